// File: rtl/lcd_angle_scheduler.sv
// Converts a 12-bit angle to BCD and streams "ANG dddd" plus a degree sign to an HD44780-style LCD controller.
// state     | meaning:  IDLE wait trigger | CONVERT double-dabble | WAIT_IDLE issue write | WAIT_ACK await busy rise | WAIT_DONE await busy fall
module lcd_angle_scheduler #(
    parameter int REFRESH_CYCLES = 2_500_000,
    parameter int ACK_TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] angle_in,
    input  logic        upd_stb,
    input  logic        lcd_busy,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_wr,
    output logic        busy,
    output logic        frame_done,
    output logic        err
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CONVERT   = 3'd1;
    localparam logic [2:0] WAIT_IDLE = 3'd2;
    localparam logic [2:0] WAIT_ACK  = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;

    localparam logic [31:0] RC_LAST = 32'(REFRESH_CYCLES - 1);
    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

    logic [2:0]  state;
    logic [31:0] rcnt;
    logic        refresh_tick;
    logic        trigger;
    logic        pending;
    logic [11:0] bin;
    logic [15:0] bcd;
    logic [11:0] bcd_adj;
    logic [3:0]  bitcnt;
    logic [3:0]  idx;
    logic [15:0] tcnt;
    logic [7:0]  xfer_byte;

    assign refresh_tick = (REFRESH_CYCLES != 0) && (rcnt == RC_LAST);
    assign trigger      = upd_stb | refresh_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt <= '0;
        end else if (REFRESH_CYCLES == 0 || refresh_tick) begin
            rcnt <= '0;
        end else begin
            rcnt <= rcnt + 32'd1;
        end
    end

    // The thousands nibble never exceeds 4 for a 12-bit input, so only the lower three need the add-3 step.
    always_comb begin
        bcd_adj = bcd[11:0];
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        case (idx)
            4'd0:    xfer_byte = 8'h80;
            4'd1:    xfer_byte = 8'h41;
            4'd2:    xfer_byte = 8'h4E;
            4'd3:    xfer_byte = 8'h47;
            4'd4:    xfer_byte = 8'h20;
            4'd5:    xfer_byte = {4'h3, bcd[15:12]};
            4'd6:    xfer_byte = {4'h3, bcd[11:8]};
            4'd7:    xfer_byte = {4'h3, bcd[7:4]};
            4'd8:    xfer_byte = {4'h3, bcd[3:0]};
            default: xfer_byte = 8'hDF;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pending    <= 1'b0;
            bin        <= '0;
            bcd        <= '0;
            bitcnt     <= '0;
            idx        <= '0;
            tcnt       <= '0;
            lcd_data   <= '0;
            lcd_rs     <= 1'b0;
            lcd_wr     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            lcd_wr     <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            if (state != IDLE && trigger) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (trigger || pending) begin
                        pending <= 1'b0;
                        bin     <= angle_in;
                        bcd     <= '0;
                        bitcnt  <= 4'd12;
                        busy    <= 1'b1;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd    <= {bcd[14:12], bcd_adj, bin[11]};
                    bin    <= {bin[10:0], 1'b0};
                    bitcnt <= bitcnt - 4'd1;
                    if (bitcnt == 4'd1) begin
                        idx   <= '0;
                        state <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (!lcd_busy) begin
                        lcd_data <= xfer_byte;
                        lcd_rs   <= (idx != 4'd0);
                        lcd_wr   <= 1'b1;
                        tcnt     <= '0;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (lcd_busy) begin
                        state <= WAIT_DONE;
                    end else if (tcnt == TO_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!lcd_busy) begin
                        if (idx == 4'd9) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= WAIT_IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_angle_scheduler.sv
// Scoreboard bench for lcd_angle_scheduler: expected transfers are queued at stimulus time and popped by a monitor.
`timescale 1ns/1ps
module tb_lcd_angle_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rst2 = 1'b0;
    logic [11:0] angle_in = '0;
    logic        upd_stb = 1'b0;
    logic        force_busy = 1'b0;
    logic        model_busy = 1'b0;
    logic        model_en = 1'b1;
    logic        lcd_busy;
    logic [7:0]  lcd_data, lcd_data2;
    logic        lcd_rs, lcd_wr, busy, frame_done, err;
    logic        lcd_rs2, lcd_wr2, busy2, frame_done2, err2;

    assign lcd_busy = force_busy | model_busy;

    always #5 clk = ~clk;

    lcd_angle_scheduler #(.REFRESH_CYCLES(0), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .angle_in(angle_in), .upd_stb(upd_stb), .lcd_busy(lcd_busy),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_wr(lcd_wr), .busy(busy),
        .frame_done(frame_done), .err(err));

    lcd_angle_scheduler #(.REFRESH_CYCLES(200), .ACK_TIMEOUT(16)) dut2 (
        .clk(clk), .reset(rst2), .angle_in(12'd0), .upd_stb(1'b0), .lcd_busy(1'b0),
        .lcd_data(lcd_data2), .lcd_rs(lcd_rs2), .lcd_wr(lcd_wr2), .busy(busy2),
        .frame_done(frame_done2), .err(err2));

    typedef struct packed {
        logic [7:0] d;
        logic       rs;
    } xfer_t;

    xfer_t exp_q[$];
    int    wr2_q[$];
    int    n_chk = 0, n_fail = 0;
    int    cyc = 0, stb_cyc = 0;
    int    wr_cnt = 0, last_wr_cyc = 0, n_done = 0, n_err = 0, last_err_cyc = 0;
    int    n_err2 = 0, n_done2 = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push_frame(input int a);
        int dg[4];
        dg[0] = a / 1000;
        dg[1] = (a / 100) % 10;
        dg[2] = (a / 10) % 10;
        dg[3] = a % 10;
        exp_q.push_back('{d: 8'h80, rs: 1'b0});
        exp_q.push_back('{d: 8'h41, rs: 1'b1});
        exp_q.push_back('{d: 8'h4E, rs: 1'b1});
        exp_q.push_back('{d: 8'h47, rs: 1'b1});
        exp_q.push_back('{d: 8'h20, rs: 1'b1});
        for (int i = 0; i < 4; i++) exp_q.push_back('{d: 8'(8'h30 + dg[i]), rs: 1'b1});
        exp_q.push_back('{d: 8'hDF, rs: 1'b1});
    endtask

    task automatic pulse_stb();
        @(negedge clk);
        upd_stb = 1'b1;
        stb_cyc = cyc;
        @(negedge clk);
        upd_stb = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int t = 0;
        while (n_done < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, n_done, target);
    endtask

    task automatic wait_wr(input int target, input int budget, input string name);
        int t = 0;
        while (wr_cnt < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, wr_cnt, target);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: outputs sampled 1 ns after the active edge.
    initial forever begin
        xfer_t e;
        @(posedge clk);
        #1;
        if (lcd_wr) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            check("wr_while_lcd_busy", int'(lcd_busy), 0);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_wr: got data 0x%0h rs %0d, required no write", lcd_data, lcd_rs);
            end else begin
                e = exp_q.pop_front();
                check("wr_data", int'(lcd_data), int'(e.d));
                check("wr_rs", int'(lcd_rs), int'(e.rs));
            end
        end
        if (frame_done) n_done++;
        if (err) begin
            n_err++;
            last_err_cyc = cyc;
        end
        if (lcd_wr2) begin
            wr2_q.push_back(cyc);
            check("auto_wr_data", int'(lcd_data2), 8'h80);
            check("auto_wr_rs", int'(lcd_rs2), 0);
        end
        if (err2) n_err2++;
        if (frame_done2) n_done2++;
    end

    // Downstream controller: busy rises one cycle after a write and stays up for 20 cycles.
    initial forever begin
        @(posedge clk);
        #1;
        if (lcd_wr && model_en) begin
            @(negedge clk);
            model_busy = 1'b1;
            repeat (20) @(negedge clk);
            model_busy = 1'b0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[3];
        int d, w, e0, t, rel, c;
        vals = '{0, 4095, 7};

        repeat (3) @(negedge clk);
        check("rst_lcd_data", int'(lcd_data), 0);
        check("rst_lcd_rs", int'(lcd_rs), 0);
        check("rst_lcd_wr", int'(lcd_wr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_err", int'(err), 0);
        reset = 1'b1;

        // Controller still initialising: frame must park until lcd_busy falls.
        force_busy = 1'b1;
        angle_in = 12'd42;
        push_frame(42);
        repeat (100) @(negedge clk);
        pulse_stb();
        repeat (4900) @(negedge clk);
        check("init_no_wr", wr_cnt, 0);
        check("init_busy_held", int'(busy), 1);
        force_busy = 1'b0;
        wait_done(1, 2000, "init_frame_done");
        check("init_queue_empty", exp_q.size(), 0);

        angle_in = 12'd1234;
        push_frame(1234);
        w = wr_cnt;
        pulse_stb();
        wait_wr(w + 1, 50, "basic_first_wr");
        check("basic_latency", last_wr_cyc - stb_cyc, 14);
        wait_done(2, 2000, "basic_frame_done");
        repeat (30) @(negedge clk);
        check("basic_one_done", n_done, 2);
        check("basic_busy_after", int'(busy), 0);
        check("basic_queue_empty", exp_q.size(), 0);

        for (int i = 0; i < 3; i++) begin
            angle_in = 12'(vals[i]);
            push_frame(vals[i]);
            d = n_done + 1;
            pulse_stb();
            wait_done(d, 2000, "boundary_frame_done");
            repeat (30) @(negedge clk);
            check("boundary_one_done", n_done, d);
        end
        check("boundary_queue_empty", exp_q.size(), 0);

        // Repeated triggers merge into one extra frame; the running frame keeps the old angle.
        angle_in = 12'd1234;
        push_frame(1234);
        push_frame(567);
        d = n_done + 2;
        w = wr_cnt;
        pulse_stb();
        wait_wr(w + 1, 50, "merge_first_wr");
        angle_in = 12'd567;
        pulse_stb();
        repeat (30) @(negedge clk);
        pulse_stb();
        repeat (30) @(negedge clk);
        pulse_stb();
        wait_done(d, 4000, "merge_frames_done");
        repeat (300) @(negedge clk);
        check("merge_single_extra", n_done, d);
        check("merge_queue_empty", exp_q.size(), 0);

        // Ack timeout: controller never acknowledges.
        model_en = 1'b0;
        angle_in = 12'd99;
        exp_q.push_back('{d: 8'h80, rs: 1'b0});
        w = wr_cnt;
        e0 = n_err;
        pulse_stb();
        wait_wr(w + 1, 50, "timeout_first_wr");
        t = 0;
        while (n_err == e0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("timeout_err", n_err, e0 + 1);
        check("timeout_err_cycle", last_err_cyc - last_wr_cyc, 16);
        check("timeout_busy", int'(busy), 0);
        repeat (100) @(negedge clk);
        check("timeout_no_more_wr", wr_cnt, w + 1);
        check("timeout_single_err", n_err, e0 + 1);
        model_en = 1'b1;

        // Reset while index 5 is in flight.
        angle_in = 12'd1234;
        push_frame(1234);
        pulse_stb();
        t = 0;
        while (exp_q.size() > 4 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("midreset_reached_idx5", exp_q.size(), 4);
        reset = 1'b0;
        #1;
        check("midreset_lcd_data", int'(lcd_data), 0);
        check("midreset_lcd_rs", int'(lcd_rs), 0);
        check("midreset_lcd_wr", int'(lcd_wr), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_frame_done", int'(frame_done), 0);
        check("midreset_err", int'(err), 0);
        exp_q.delete();
        w = wr_cnt;
        d = n_done;
        @(negedge clk);
        reset = 1'b1;
        repeat (300) @(negedge clk);
        check("midreset_no_wr", wr_cnt, w);
        check("midreset_no_done", n_done, d);
        check("midreset_idle", int'(busy), 0);

        // Auto refresh every 200 cycles: trigger at cycle 199, first write 14 cycles later.
        @(negedge clk);
        rst2 = 1'b1;
        rel = cyc;
        for (int n = 0; n < 3; n++) begin
            t = 0;
            while (wr2_q.size() == 0 && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (wr2_q.size() == 0) begin
                check("auto_wr_seen", 0, 1);
            end else begin
                c = wr2_q.pop_front();
                check("auto_wr_cycle", c - rel, 213 + 200 * n);
            end
        end
        check("auto_err_count", n_err2, 2);
        check("auto_busy_in_frame", int'(busy2), 1);
        check("auto_no_done", n_done2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
